// File: rtl/data_mem_lanes.sv
// rtl/data_mem_lanes.sv - big-endian byte-addressed data memory with sized loads/stores, fixed latency and clear-on-reset
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   req_valid/req_ready            request handshake, accepted on an edge where both are 1
//   req_write, req_size            store/load and access size (0 byte, 1 half, 2 word, 3 dword)
//   req_signed, req_addr           load sign-extension select, byte address
//   req_wdata                      right-aligned store data
//   rsp_valid, rsp_rdata, rsp_err  one-cycle response strobe, load result, fault flag
//   init_done                      high once the post-reset clear has finished
module data_mem_lanes #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int BASE_ADDR   = 1024,
    parameter int READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);
    localparam int BPW    = DATA_W / 8;
    localparam int NWORDS = DEPTH_BYTES / BPW;
    localparam int AW     = $clog2(DEPTH_BYTES);
    localparam int LB     = $clog2(BPW);
    localparam int WIW    = AW - LB;
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(DEPTH_BYTES);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [7:0]        mem [DEPTH_BYTES];
    logic [1:0]        state;
    logic [WIW-1:0]    clr_idx;
    logic [1:0]        cnt;
    logic              rsp_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic              accept;
    logic              fault;
    logic [3:0]        nbytes;
    logic [2:0]        align_mask;
    logic [32:0]       end_addr;
    logic [AW-1:0]     off;
    logic [63:0]       ld_raw;
    logic [63:0]       ld_ext;
    logic [63:0]       ext_mask;
    logic              ld_msb;
    logic [63:0]       st_align;

    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // A response in the same cycle as rst is suppressed, so the strobe is gated by rst.
    assign rsp_valid = rsp_q && !rst;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid && err_q;

    // BASE_ADDR is a multiple of DEPTH_BYTES, so the low address bits are the offset.
    assign off = req_addr[AW-1:0];

    always_comb begin
        nbytes     = 4'd1 << req_size;
        align_mask = 3'(nbytes - 4'd1);
        end_addr   = {1'b0, req_addr} + {29'd0, nbytes};
        fault      = ({1'b0, req_addr} < 33'(BASE_ADDR)) || (end_addr > LIMIT) ||
                     ((req_addr[2:0] & align_mask) != 3'd0) ||
                     ((req_size == 2'd3) && (DATA_W == 32));

        // Big-endian: the lowest-addressed byte ends up most significant.
        ld_raw = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                ld_raw = {ld_raw[55:0], mem[off + AW'(i)]};
            end
        end
        ld_msb   = ld_raw[{nbytes, 3'b000} - 7'd1];
        ext_mask = ~64'd0 << {nbytes, 3'b000};
        ld_ext   = (req_signed && ld_msb) ? (ld_raw | ext_mask) : ld_raw;

        // Left-align the item so byte i of the access is always st_align[63-8*i -: 8].
        st_align = 64'(req_wdata) << {4'd8 - nbytes, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            for (int j = 0; j < BPW; j++) begin
                mem[{clr_idx, LB'(j)}] <= 8'd0;
            end
        end else if (accept && req_write && !fault) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < nbytes) begin
                    mem[off + AW'(i)] <= st_align[63-8*i -: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLEAR;
            clr_idx   <= '0;
            init_done <= 1'b0;
            cnt       <= 2'd0;
            rsp_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rsp_q <= 1'b0;
            case (state)
                S_CLEAR: begin
                    if (clr_idx == WIW'(NWORDS - 1)) begin
                        state     <= S_IDLE;
                        init_done <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        rdata_q <= (fault || req_write) ? '0 : ld_ext[DATA_W-1:0];
                        err_q   <= fault;
                        // The response cycle is itself an IDLE cycle, so the
                        // WAIT countdown covers only READ_LAT-1 cycles.
                        if (READ_LAT == 1) begin
                            rsp_q <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 2'(READ_LAT - 2);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 2'd0) begin
                        state <= S_IDLE;
                        rsp_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_lanes.sv
// tb/tb_data_mem_lanes.sv - directed self-checking bench for data_mem_lanes
module tb_data_mem_lanes;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int checks = 0;
    int failures = 0;

    data_mem_lanes #(
        .DATA_W(32), .DEPTH_BYTES(1024), .BASE_ADDR(1024), .READ_LAT(3)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request and waits for its response; rdata/err return the response.
    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int n;
        bit got;
        rd = 32'hDEAD_BEEF;
        er = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_ready_timeout"}, 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                rd = rsp_rdata;
                er = rsp_err;
            end
        end
        if (!got) check({tag, "_rsp_timeout"}, 0, 1);
    endtask

    task automatic wait_clear(input string tag);
        int cyc;
        cyc = 0;
        @(negedge clk);
        rst = 1'b0;
        while (cyc < 1000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (init_done) break;
        end
        check({tag, "_clear_cycles"}, 64'(cyc), 64'd256);
        check({tag, "_ready_with_done"}, 64'(req_ready), 64'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    logic        rv_s [1:6];
    logic        rdy_s [1:6];
    logic [31:0] dat_s [1:6];
    bit          saw_rsp;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(req_ready), 0);
        check("reset_rsp_valid", 64'(rsp_valid), 0);
        check("reset_rdata", 64'(rsp_rdata), 0);
        check("reset_err", 64'(rsp_err), 0);
        check("reset_init_done", 64'(init_done), 0);
        wait_clear("boot");

        do_req("ld_cleared", 0, 2'd2, 0, 32'h400, 0, rd, er);
        check("ld_cleared_data", 64'(rd), 64'h0);
        check("ld_cleared_err", 64'(er), 0);

        do_req("st_word", 1, 2'd2, 0, 32'h404, 32'h1122_3344, rd, er);
        check("st_word_rdata", 64'(rd), 0);
        check("st_word_err", 64'(er), 0);
        do_req("ld_b405", 0, 2'd0, 0, 32'h405, 0, rd, er);
        check("ld_b405", 64'(rd), 64'h22);
        do_req("ld_h406", 0, 2'd1, 0, 32'h406, 0, rd, er);
        check("ld_h406", 64'(rd), 64'h3344);
        do_req("st_b407", 1, 2'd0, 0, 32'h407, 32'hFFFF_FFAB, rd, er);
        do_req("ld_w404", 0, 2'd2, 0, 32'h404, 0, rd, er);
        check("ld_w404", 64'(rd), 64'h1122_33AB);
        do_req("ld_h404_s", 0, 2'd1, 1, 32'h404, 0, rd, er);
        check("ld_h404_signed_pos", 64'(rd), 64'h1122);

        do_req("st_b410", 1, 2'd0, 0, 32'h410, 32'h0000_0080, rd, er);
        do_req("ld_b410_s", 0, 2'd0, 1, 32'h410, 0, rd, er);
        check("ld_b410_signed", 64'(rd), 64'hFFFF_FF80);
        do_req("ld_b410_u", 0, 2'd0, 0, 32'h410, 0, rd, er);
        check("ld_b410_unsigned", 64'(rd), 64'h80);
        do_req("ld_h410_s", 0, 2'd1, 1, 32'h410, 0, rd, er);
        check("ld_h410_signed", 64'(rd), 64'hFFFF_8000);

        do_req("f_below", 0, 2'd2, 0, 32'h3FC, 0, rd, er);
        check("f_below_err", 64'(er), 1);
        check("f_below_rdata", 64'(rd), 0);
        do_req("f_top", 1, 2'd2, 0, 32'h7FE, 32'hCAFE_F00D, rd, er);
        check("f_top_err", 64'(er), 1);
        check("f_top_rdata", 64'(rd), 0);
        do_req("f_top_chk", 0, 2'd2, 0, 32'h7FC, 0, rd, er);
        check("f_top_mem", 64'(rd), 0);
        do_req("ok_top_b", 0, 2'd0, 0, 32'h7FF, 0, rd, er);
        check("ok_top_byte_err", 64'(er), 0);
        do_req("f_half", 1, 2'd1, 0, 32'h401, 32'h0000_BEEF, rd, er);
        check("f_half_err", 64'(er), 1);
        check("f_half_rdata", 64'(rd), 0);
        do_req("f_half_chk", 0, 2'd2, 0, 32'h400, 0, rd, er);
        check("f_half_mem", 64'(rd), 0);
        do_req("f_dw", 1, 2'd3, 0, 32'h408, 32'h5555_5555, rd, er);
        check("f_dw_err", 64'(er), 1);
        check("f_dw_rdata", 64'(rd), 0);
        do_req("f_dw_chk", 0, 2'd2, 0, 32'h408, 0, rd, er);
        check("f_dw_mem", 64'(rd), 0);
        check("f_dw_chk_err", 64'(er), 0);

        // Handshake timing: request presented in cycle 0, accepted at its closing edge;
        // a second request (byte load at 0x404) is held from the next cycle on.
        @(negedge clk);
        check("lat_ready_pre", 64'(req_ready), 1);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h404;
        @(posedge clk);
        #1 req_size = 2'd0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rv_s[c] = rsp_valid;
            rdy_s[c] = req_ready;
            dat_s[c] = rsp_rdata;
            if (c == 3) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        check("lat_rv_c1", 64'(rv_s[1]), 0);
        check("lat_rv_c2", 64'(rv_s[2]), 0);
        check("lat_rv_c3", 64'(rv_s[3]), 1);
        check("lat_rv_c4", 64'(rv_s[4]), 0);
        check("lat_rdy_c1", 64'(rdy_s[1]), 0);
        check("lat_rdy_c2", 64'(rdy_s[2]), 0);
        check("lat_rdy_c3", 64'(rdy_s[3]), 1);
        check("lat_rdy_c4", 64'(rdy_s[4]), 0);
        check("lat_data_c3", 64'(dat_s[3]), 64'h1122_33AB);
        check("lat_rv2_c6", 64'(rv_s[6]), 1);
        check("lat_data2_c6", 64'(dat_s[6]), 64'h11);

        // Reset while a load is in flight.
        @(negedge clk);
        req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h404;
        @(posedge clk);
        #1 req_valid = 1'b0;
        saw_rsp = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1;
        end
        check("rst_no_rsp", 64'(saw_rsp), 0);
        check("rst_init_done_low", 64'(init_done), 0);
        check("rst_ready_low", 64'(req_ready), 0);
        wait_clear("reclear");
        do_req("rst_ld404", 0, 2'd2, 0, 32'h404, 0, rd, er);
        check("rst_ld404", 64'(rd), 0);
        do_req("rst_ld410", 0, 2'd0, 0, 32'h410, 0, rd, er);
        check("rst_ld410", 64'(rd), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
